// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// State encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_bit_slice.sv
// One full-adder bit slice: the only arithmetic in the serial adder.
// Carry is the majority of the three inputs.
module fa_bit_slice (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    // Sum is the parity of the inputs; carry is generate or propagate.
    always_comb begin
        s    = a ^ b ^ c;
        cout = (a & b) | (c & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Carry flop closes the loop from slice cout back to slice cin.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             accept;
    logic             last;
    logic             s_sum;
    logic             s_cout;

    fa_bit_slice u_slice (
        .a    (sha[0]),
        .b    (shb[0]),
        .c    (carry),
        .s    (s_sum),
        .cout (s_cout)
    );

    // State register; reset returns to IDLE and aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshake outputs and the terminal-bit decode.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        last     = 1'b0;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                last = (cnt == CW'(WIDTH - 1));
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                ready    = 1'b1;
                done     = 1'b1;
                accept   = start;
                state_nx = start ? S_RUN : S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one shift per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sha   <= '0;
            shb   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            sha   <= a;
            shb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            sum   <= '0;
        end else if (busy) begin
            sha   <= sha >> 1;
            shb   <= shb >> 1;
            carry <= s_cout;
            cnt   <= cnt + CW'(1);
            sum   <= {s_sum, sum[WIDTH-1:1]};
            if (last) begin
                cout <= s_cout;
            end
        end
    end

endmodule
